// File: rtl/rr_mux_pkg.sv
// Shared types and helpers for the round-robin mux/arbiter block.
package rr_mux_pkg;

  // Arbitration mode carried by the RR parameter.
  typedef enum logic {
    ARB_FIXED = 1'b0,
    ARB_RR    = 1'b1
  } arb_mode_t;

  // Width of a channel index; never below one bit so N_CH=1 still has a port.
  function automatic int ch_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Grant generator: rotate requests so the search starts after the last
// winner, priority-encode the lowest set bit, rotate the index back.
module rr_arbiter
  import rr_mux_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int RR   = 1,
  localparam int CHW = ch_w(N_CH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] req,
  input  logic            advance,
  output logic [N_CH-1:0] grant_oh,
  output logic [CHW-1:0]  grant_idx
);

  localparam arb_mode_t      MODE    = (RR != 0) ? ARB_RR : ARB_FIXED;
  localparam logic [CHW-1:0] LAST_CH = CHW'(N_CH - 1);
  localparam logic [CHW:0]   N_EXT   = (CHW+1)'(N_CH);

  logic [CHW-1:0]    r_last;
  logic [CHW-1:0]    w_start;
  logic [CHW-1:0]    w_pe;
  logic [2*N_CH-1:0] w_dbl;
  logic [N_CH-1:0]   w_rot;
  logic              w_any;
  logic [CHW:0]      w_sum;

  // Search origin: one past the last winner (wrapping), or 0 in fixed mode.
  always_comb begin
    w_start = '0;
    if (MODE == ARB_RR && r_last != LAST_CH) w_start = r_last + 1'b1;
  end

  // Doubling the vector turns the rotation into a plain part-select.
  assign w_dbl = {req, req};
  assign w_rot = w_dbl[w_start +: N_CH];

  // Lowest set bit of the rotated vector (the last write in the loop wins).
  always_comb begin
    w_any = 1'b0;
    w_pe  = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (w_rot[i]) begin
        w_any = 1'b1;
        w_pe  = CHW'(i);
      end
    end
  end

  // Undo the rotation: (pe + start) mod N_CH, both operands already < N_CH.
  assign w_sum = {1'b0, w_pe} + {1'b0, w_start};

  always_comb begin
    grant_idx = w_sum[CHW-1:0];
    if (w_sum >= N_EXT) grant_idx = CHW'(w_sum - N_EXT);
  end

  // One-hot view of the grant, empty when nobody requests.
  always_comb begin
    grant_oh = '0;
    if (w_any) grant_oh[grant_idx] = 1'b1;
  end

  // Pointer moves only on a real transfer, so stalls keep fairness intact.
  always_ff @(posedge clk) begin
    if (rst)                            r_last <= LAST_CH;
    else if (advance && MODE == ARB_RR) r_last <= grant_idx;
  end

endmodule

// File: rtl/rr_mux_arbiter.sv
// N-channel valid/ready mux with internal arbitration and a registered
// output stage; full throughput, no bubble on simultaneous drain and load.
module rr_mux_arbiter
  import rr_mux_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int W    = 8,
  parameter int RR   = 1,
  localparam int CHW = ch_w(N_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_CH-1:0]   in_valid,
  output logic [N_CH-1:0]   in_ready,
  input  logic [N_CH*W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [W-1:0]      out_data,
  output logic [CHW-1:0]    out_ch
);

  logic            r_out_valid;
  logic [W-1:0]    r_out_data;
  logic [CHW-1:0]  r_out_ch;

  logic            w_load;
  logic            w_any;
  logic            w_xfer;
  logic [N_CH-1:0] w_grant_oh;
  logic [CHW-1:0]  w_grant_idx;
  logic [W-1:0]    w_ch_data [N_CH];

  // Output register is free when empty or being drained this cycle.
  assign w_load = !r_out_valid || out_ready;
  assign w_any  = |w_grant_oh;
  assign w_xfer = w_load && w_any && !rst;

  assign in_ready = (w_load && !rst) ? w_grant_oh : '0;

  rr_arbiter #(
    .N_CH (N_CH),
    .RR   (RR)
  ) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (in_valid),
    .advance   (w_xfer),
    .grant_oh  (w_grant_oh),
    .grant_idx (w_grant_idx)
  );

  // Unpack the flat data bus so the mux is a simple array index.
  for (genvar g = 0; g < N_CH; g++) begin : g_unpack
    assign w_ch_data[g] = in_data[g*W +: W];
  end

  // Output stage: load the granted word, go empty with no grant, hold on stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_ch    <= '0;
    end else if (w_load) begin
      if (w_any) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_ch_data[w_grant_idx];
        r_out_ch    <= w_grant_idx;
      end else begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_ch    = r_out_ch;

endmodule
